// File: rtl/mul_add_sched.sv
// Round-robin scheduler sharing one fixed-latency mul_add_1 pipeline between N_REQ requesters.
// Issues carry a tag down a shift register so returning results land in a credit-protected FIFO.
module mul_add_sched #(
    parameter int N_REQ      = 4,
    parameter int LATENCY    = 9,
    parameter int FIFO_DEPTH = 16,
    localparam int ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*40-1:0]   req_a,
    input  logic [N_REQ*38-1:0]   req_b,
    input  logic [N_REQ-1:0]      req_c,
    output logic [39:0]           mac_a,
    output logic [37:0]           mac_b,
    output logic                  mac_c,
    input  logic [8:0]            mac_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8:0]            out_data,
    output logic [ID_W-1:0]       out_id,
    output logic                  busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int ENT_W = ID_W + 9;

    logic [ID_W-1:0]             last;
    logic [ID_W-1:0]             grant_id;
    logic [ID_W-1:0]             cand;
    logic                        grant_found;
    logic                        can_issue;
    logic                        issue;
    logic [39:0]                 sel_a;
    logic [37:0]                 sel_b;
    logic                        sel_c;
    logic [CNT_W-1:0]            inflight;
    logic [CNT_W-1:0]            fifo_count;
    logic [SUM_W-1:0]            credit_used;
    logic [LATENCY:0]            tag_v;
    logic [LATENCY:0][ID_W-1:0]  tag_id;
    logic                        capture;
    logic                        push;
    logic                        pop;
    logic [PTR_W-1:0]            wr_ptr;
    logic [PTR_W-1:0]            rd_ptr;
    logic [ENT_W-1:0]            mem [FIFO_DEPTH];
    logic [ENT_W-1:0]            head;

    // Search starts one past the last winner, so the winner just served has lowest priority.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(last) + k) % N_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        sel_c = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel_a = req_a[i*40 +: 40];
                sel_b = req_b[i*38 +: 38];
                sel_c = req_c[i];
            end
        end
    end

    // Credit covers results still in the pipe plus those already buffered, so a capture always has room.
    assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
    assign can_issue   = credit_used < SUM_W'(FIFO_DEPTH);

    always_comb begin
        req_ready = '0;
        if (grant_found && can_issue && !rst) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign issue   = |(req_valid & req_ready);
    assign capture = tag_v[LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last     <= ID_W'(N_REQ - 1);
            mac_a    <= '0;
            mac_b    <= '0;
            mac_c    <= 1'b0;
            tag_v    <= '0;
            tag_id   <= '0;
            inflight <= '0;
        end else begin
            if (issue) begin
                last  <= grant_id;
                mac_a <= sel_a;
                mac_b <= sel_b;
                mac_c <= sel_c;
            end
            tag_v  <= {tag_v[LATENCY-1:0], issue};
            tag_id <= {tag_id[LATENCY-1:0], grant_id};
            case ({issue, capture})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    assign push = capture;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage needs no reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {tag_id[LATENCY], mac_result};
        end
    end

    assign head      = mem[rd_ptr];
    assign out_valid = (fifo_count != '0);
    assign out_id    = out_valid ? head[ENT_W-1:9] : '0;
    assign out_data  = out_valid ? head[8:0] : '0;
    assign busy      = (inflight != '0) || out_valid;

    a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && fifo_count == CNT_W'(FIFO_DEPTH)));
    a_credit_bound: assert property (@(posedge clk) disable iff (rst)
        credit_used <= SUM_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_mul_add_sched.sv
// Directed bench for mul_add_sched with a behavioural 9-stage stand-in for mul_add_1.
// Operands a = n<<24, b = 1<<24, c = 1 make the stand-in return n, so expected data is hand-known.
module tb_mul_add_sched;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int W  = IW + 9;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*40-1:0] req_a;
    logic [N*38-1:0] req_b;
    logic [N-1:0]    req_c;
    logic [39:0]     mac_a;
    logic [37:0]     mac_b;
    logic            mac_c;
    logic [8:0]      mac_result;
    logic            out_valid;
    logic            out_ready;
    logic [8:0]      out_data;
    logic [IW-1:0]   out_id;
    logic            busy;

    int n_vec = 0;
    int n_err = 0;
    int n_pop = 0;
    int cyc   = 0;
    int next_n = 1;
    int cur_n [N];
    int hs_cnt;
    int hs_id;
    logic [N-1:0] accepted = '0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_exp;
    logic [8:0]   dp [9];

    mul_add_sched #(.N_REQ(4), .LATENCY(9), .FIFO_DEPTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_c      (req_c),
        .mac_a      (mac_a),
        .mac_b      (mac_b),
        .mac_c      (mac_c),
        .mac_result (mac_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_id     (out_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath stand-in: sat((a*b >> 48) + c - 1) into 0..511, nine register stages.
    function automatic logic [8:0] dp_f(input logic [39:0] a, input logic [37:0] b, input logic c);
        logic [77:0] p;
        logic [31:0] s;
        p = {38'b0, a} * {40'b0, b};
        s = {2'b0, p[77:48]} + {31'b0, c};
        if (s == 0) return 9'd0;
        s = s - 1;
        if (s > 511) return 9'd511;
        return s[8:0];
    endfunction

    always @(posedge clk) begin
        dp[0] <= dp_f(mac_a, mac_b, mac_c);
        for (int k = 1; k < 9; k++) dp[k] <= dp[k-1];
    end
    assign mac_result = dp[8];

    // Scoreboard: every popped result must match the oldest recorded handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_pop++;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL out_unexpected: got id=%0d data=%0d, expected no result", out_id, out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({out_id, out_data} !== mon_exp) begin
                    n_err++;
                    $display("FAIL out_order: got id=%0d data=%0d, expected id=%0d data=%0d",
                             out_id, out_data, mon_exp[W-1:9], mon_exp[8:0]);
                end
            end
        end
    end

    task automatic load(input int i, input int n);
        req_a[i*40 +: 40] = 40'(n) << 24;
        req_b[i*38 +: 38] = 38'd1 << 24;
        req_c[i] = 1'b1;
        cur_n[i] = n;
    endtask

    task automatic load_next(input int i);
        load(i, next_n);
        next_n = next_n % 250 + 1;
    endtask

    // Start of a cycle: requesters accepted last cycle present fresh operands.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (accepted[i]) load_next(i);
        accepted = '0;
    endtask

    // Middle of a cycle: record the handshake that the coming edge will complete.
    task automatic obs();
        @(negedge clk);
        hs_cnt = 0;
        hs_id  = -1;
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                hs_cnt++;
                hs_id = i;
                accepted[i] = 1'b1;
                exp_q.push_back({IW'(i), 9'(cur_n[i])});
            end
        end
    endtask

    task automatic drain(input string name);
        int k = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || busy) && k < 300) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (k >= 300) begin
            n_err++;
            $display("FAIL %s_drain: queue=%0d busy=%0d after %0d cycles, required empty and idle",
                     name, exp_q.size(), busy, k);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) load_next(i);
        req_valid = '1;
        repeat (3) @(negedge clk);
        n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_req_ready: got %b, required 0000", req_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b, required 0", busy); end
        n_vec++; if ({out_id, out_data} !== '0) begin n_err++; $display("FAIL rst_out_data: got id=%0d data=%0d, required 0", out_id, out_data); end
        n_vec++; if ({mac_a, mac_b, mac_c} !== '0) begin n_err++; $display("FAIL rst_mac: got a=%h b=%h c=%b, required 0", mac_a, mac_b, mac_c); end
        tick();
        rst = 1'b0;
        obs();
        n_vec++; if (req_ready !== 4'b0001 || hs_id != 0) begin n_err++; $display("FAIL rst_first_grant: got ready=%b, required 0001", req_ready); end
        tick();
        req_valid = '0;
        obs();
        drain("reset");
    endtask

    task automatic test_single();
        logic [39:0] va [2];
        logic [37:0] vb [2];
        logic        vc [2];
        int          ve [2];
        int          early;
        va[0] = 40'h01_0000_0000; vb[0] = 38'h100_0000; vc[0] = 1'b1; ve[0] = 256;
        va[1] = 40'h0;            vb[1] = 38'h1;        vc[1] = 1'b0; ve[1] = 0;
        for (int v = 0; v < 2; v++) begin
            tick();
            out_ready = 1'b1;
            req_valid = 4'b0100;
            req_a[2*40 +: 40] = va[v];
            req_b[2*38 +: 38] = vb[v];
            req_c[2] = vc[v];
            cur_n[2] = ve[v];
            obs();
            n_vec++; if (hs_id != 2) begin n_err++; $display("FAIL single_grant%0d: got %0d, required 2", v, hs_id); end
            early = 0;
            for (int k = 1; k <= 11; k++) begin
                tick();
                req_valid = '0;
                obs();
                if (k == 1) begin
                    n_vec++;
                    if (mac_a !== va[v] || mac_b !== vb[v] || mac_c !== vc[v]) begin
                        n_err++;
                        $display("FAIL single_mac%0d: got a=%h b=%h c=%b, required a=%h b=%h c=%b",
                                 v, mac_a, mac_b, mac_c, va[v], vb[v], vc[v]);
                    end
                end
                if (k < 11 && out_valid) early++;
                if (k == 11) begin
                    n_vec++;
                    if (out_valid !== 1'b1 || out_id !== 2'd2 || out_data !== 9'(ve[v])) begin
                        n_err++;
                        $display("FAIL single_result%0d: got valid=%b id=%0d data=%0d, required 1/2/%0d",
                                 v, out_valid, out_id, out_data, ve[v]);
                    end
                end
            end
            n_vec++; if (early != 0) begin n_err++; $display("FAIL single_early%0d: out_valid seen %0d cycles early, required 0", v, early); end
        end
        drain("single");
    endtask

    task automatic test_fair();
        int bubbles = 0;
        tick();
        rst = 1'b1;
        req_valid = '0;
        tick();
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < N; i++) load_next(i);
        for (int c = 0; c < 40; c++) begin
            tick();
            out_ready = 1'b1;
            req_valid = (c < 24) ? 4'b1111 : 4'b0000;
            obs();
            if (c < 24) begin
                n_vec++;
                if (hs_cnt != 1 || hs_id != c % 4) begin
                    n_err++;
                    $display("FAIL fair_grant: cycle %0d got %0d grants id=%0d, required 1 grant id=%0d", c, hs_cnt, hs_id, c % 4);
                end
            end
            if (c >= 11 && c < 35 && !out_valid) bubbles++;
        end
        n_vec++; if (bubbles != 0) begin n_err++; $display("FAIL fair_bubbles: got %0d, required 0", bubbles); end
        drain("fair");
    endtask

    task automatic test_backpressure();
        int total = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            req_valid = '1;
            obs();
            total += hs_cnt;
        end
        n_vec++; if (total != 16) begin n_err++; $display("FAIL bp_handshakes: got %0d, required 16", total); end
        n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_stalled: got ready=%b, required 0000", req_ready); end
        tick();
        out_ready = 1'b1;
        obs();
        n_vec++; if (hs_cnt != 0) begin n_err++; $display("FAIL bp_pop_cycle: got %0d handshakes, required 0", hs_cnt); end
        tick();
        obs();
        n_vec++; if (hs_cnt != 1) begin n_err++; $display("FAIL bp_resume: got %0d handshakes, required 1", hs_cnt); end
        tick();
        req_valid = '0;
        obs();
        drain("bp");
    endtask

    task automatic test_full_boundary();
        int total = 0;
        int extra = 0;
        int p0;
        out_ready = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            req_valid = '1;
            obs();
            total += hs_cnt;
        end
        n_vec++; if (total != 16) begin n_err++; $display("FAIL fb_fill: got %0d, required 16", total); end
        tick();
        out_ready = 1'b1;
        obs();
        n_vec++; if (hs_cnt != 0) begin n_err++; $display("FAIL fb_pulse_cycle: got %0d handshakes, required 0", hs_cnt); end
        tick();
        out_ready = 1'b0;
        obs();
        n_vec++; if (hs_cnt != 1) begin n_err++; $display("FAIL fb_next_cycle: got %0d handshakes, required 1", hs_cnt); end
        for (int c = 0; c < 25; c++) begin
            tick();
            obs();
            extra += hs_cnt;
        end
        n_vec++; if (extra != 0) begin n_err++; $display("FAIL fb_extra: got %0d handshakes, required 0", extra); end
        tick();
        req_valid = '0;
        obs();
        p0 = n_pop;
        drain("fb");
        n_vec++; if (n_pop - p0 != 16) begin n_err++; $display("FAIL fb_occupancy: got %0d results, required 16", n_pop - p0); end
    endtask

    task automatic test_midop_reset();
        int cnt = 0;
        int bad = 0;
        int early = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            req_valid = 4'b0001;
            obs();
            cnt += hs_cnt;
        end
        n_vec++; if (cnt != 8) begin n_err++; $display("FAIL mid_issue: got %0d, required 8", cnt); end
        for (int c = 0; c < 5; c++) begin
            tick();
            req_valid = '0;
            obs();
        end
        tick();
        rst = 1'b1;
        obs();
        exp_q.delete();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b, required 0", out_valid); end
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        obs();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b, required 0", busy); end
        for (int c = 0; c < 20; c++) begin
            tick();
            obs();
            if (out_valid) bad++;
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL mid_stale: got %0d valid cycles, required 0", bad); end
        tick();
        req_valid = 4'b0010;
        load(1, 77);
        obs();
        n_vec++; if (hs_id != 1) begin n_err++; $display("FAIL mid_new_grant: got %0d, required 1", hs_id); end
        for (int k = 1; k <= 11; k++) begin
            tick();
            req_valid = '0;
            obs();
            if (k < 11 && out_valid) early++;
            if (k == 11) begin
                n_vec++;
                if (out_valid !== 1'b1 || out_id !== 2'd1 || out_data !== 9'd77) begin
                    n_err++;
                    $display("FAIL mid_new_result: got valid=%b id=%0d data=%0d, required 1/1/77", out_valid, out_id, out_data);
                end
            end
        end
        n_vec++; if (early != 0) begin n_err++; $display("FAIL mid_new_early: got %0d, required 0", early); end
        drain("mid");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        req_c = '0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_fair();
        test_backpressure();
        test_full_boundary();
        test_midop_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
